// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, widths and colour-bar palette
package vga_pkg;

   localparam int CNT_W = 11;
   localparam int RGB_W = 12;

   // 800x600 @ 60 Hz, 40 MHz pixel clock
   localparam int DEF_H_ACTIVE = 800;
   localparam int DEF_H_FP     = 40;
   localparam int DEF_H_SYNC   = 128;
   localparam int DEF_H_BP     = 88;
   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_ACTIVE = 600;
   localparam int DEF_V_FP     = 1;
   localparam int DEF_V_SYNC   = 4;
   localparam int DEF_V_BP     = 23;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam logic [RGB_W-1:0] C_WHITE   = 12'hFFF;
   localparam logic [RGB_W-1:0] C_YELLOW  = 12'hFF0;
   localparam logic [RGB_W-1:0] C_CYAN    = 12'h0FF;
   localparam logic [RGB_W-1:0] C_GREEN   = 12'h0F0;
   localparam logic [RGB_W-1:0] C_MAGENTA = 12'hF0F;
   localparam logic [RGB_W-1:0] C_RED     = 12'hF00;
   localparam logic [RGB_W-1:0] C_BLUE    = 12'h00F;
   localparam logic [RGB_W-1:0] C_BLACK   = 12'h000;

   // Bar colours left to right across the active line
   function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
      logic [RGB_W-1:0] c;
      case (idx)
         3'd0:    c = C_WHITE;
         3'd1:    c = C_YELLOW;
         3'd2:    c = C_CYAN;
         3'd3:    c = C_GREEN;
         3'd4:    c = C_MAGENTA;
         3'd5:    c = C_RED;
         3'd6:    c = C_BLUE;
         default: c = C_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: wrapping counter with blank/sync window decode
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int   TOTAL    = DEF_H_TOTAL,
   parameter int   ACTIVE   = DEF_H_ACTIVE,
   parameter int   FP       = DEF_H_FP,
   parameter int   SYNC     = DEF_H_SYNC,
   parameter logic SYNC_POL = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_step,
   output logic [CNT_W-1:0] o_count,
   output logic             o_wrap,
   output logic             o_blnk,
   output logic             o_sync
);

   localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] ACT     = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
   localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_next;
   logic             r_blnk;
   logic             r_sync;
   logic             w_last;

   assign w_last  = (r_count == LAST);
   assign o_wrap  = i_step & w_last;
   assign o_count = r_count;
   assign o_blnk  = r_blnk;
   assign o_sync  = r_sync;

   // Next count: hold when not stepping, wrap after the last position
   always_comb begin
      w_next = r_count;
      if (i_step) begin
         w_next = w_last ? '0 : r_count + 1'b1;
      end
   end

   // Count and flags are registered from the same next value so they never skew
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
         r_blnk  <= 1'b0;
         r_sync  <= ~SYNC_POL;
      end else begin
         r_count <= w_next;
         r_blnk  <= (w_next >= ACT);
         r_sync  <= ((w_next >= SYNC_LO) && (w_next < SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing source; VGA_TIMING_TEST_PATTERN_EN adds colour bars on rgb
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             hblnk,
   output logic             vblnk,
   output logic [RGB_W-1:0] rgb,
   output logic             line_start,
   output logic             frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
          V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
          H_TOTAL >= 2048 || V_TOTAL >= 2048) begin : g_bad_timing
         $error("vga_timing_gen: timing parameters out of range");
      end
   endgenerate

   logic w_h_wrap;
   logic w_v_wrap;
   logic r_line_start;
   logic r_frame_start;

   vga_axis_counter #(
      .TOTAL    (H_TOTAL),
      .ACTIVE   (H_ACTIVE),
      .FP       (H_FP),
      .SYNC     (H_SYNC),
      .SYNC_POL (SYNC_POL)
   ) u_h_axis (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_step  (en),
      .o_count (hcount),
      .o_wrap  (w_h_wrap),
      .o_blnk  (hblnk),
      .o_sync  (hsync)
   );

   vga_axis_counter #(
      .TOTAL    (V_TOTAL),
      .ACTIVE   (V_ACTIVE),
      .FP       (V_FP),
      .SYNC     (V_SYNC),
      .SYNC_POL (SYNC_POL)
   ) u_v_axis (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_step  (w_h_wrap),
      .o_count (vcount),
      .o_wrap  (w_v_wrap),
      .o_blnk  (vblnk),
      .o_sync  (vsync)
   );

   // Strobes mark the cycle the counters land on 0; they hold while en is low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_line_start  <= 1'b1;
         r_frame_start <= 1'b1;
      end else if (en) begin
         r_line_start  <= w_h_wrap;
         r_frame_start <= w_v_wrap;
      end
   end

   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

`ifdef VGA_TIMING_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
   localparam logic [CNT_W-1:0] BAR_W_C      = CNT_W'(BAR_W);
   localparam logic [CNT_W-1:0] H_ACT_C      = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_LAST_ACT_C = CNT_W'(V_ACTIVE - 1);

   logic [CNT_W-1:0] w_h_next;
   logic [CNT_W-1:0] w_bar_idx;
   logic [2:0]       w_bar;
   logic             w_h_blnk_next;
   logic             w_v_blnk_next;
   logic [RGB_W-1:0] r_rgb;

   // Next-position decode so the bar colour lines up with hcount like the flags
   always_comb begin
      w_h_next = hcount;
      if (en) begin
         w_h_next = w_h_wrap ? '0 : hcount + 1'b1;
      end
      w_h_blnk_next = (w_h_next >= H_ACT_C);
      w_v_blnk_next = vblnk;
      if (w_v_wrap) begin
         w_v_blnk_next = 1'b0;
      end else if (w_h_wrap) begin
         w_v_blnk_next = (vcount >= V_LAST_ACT_C);
      end
      w_bar_idx = w_h_next / BAR_W_C;
      w_bar     = (w_bar_idx > 11'd7) ? 3'd7 : w_bar_idx[2:0];
   end

   // Colour bars in the active area, black during either blanking interval
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rgb <= '0;
      end else begin
         r_rgb <= (w_h_blnk_next || w_v_blnk_next) ? '0 : bar_colour(w_bar);
      end
   end

   assign rgb = r_rgb;
`else
   assign rgb = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

   logic        clk = 1'b0;
   logic        rst, en, rst_s, en_s;
   logic [10:0] hcount, vcount, hcount_s, vcount_s;
   logic        hsync, vsync, hblnk, vblnk, line_start, frame_start;
   logic        hsync_s, vsync_s, hblnk_s, vblnk_s, line_start_s, frame_start_s;
   logic [11:0] rgb, rgb_s;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vga_timing_gen u_dut (
      .clk(clk), .rst(rst), .en(en),
      .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
      .hblnk(hblnk), .vblnk(vblnk), .rgb(rgb),
      .line_start(line_start), .frame_start(frame_start)
   );

   // Small raster, active-low sync: H 8/2/3/2 (total 15), V 6/1/2/3 (total 12), frame 180 clks
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
      .SYNC_POL(1'b0)
   ) u_small (
      .clk(clk), .rst(rst_s), .en(en_s),
      .hcount(hcount_s), .vcount(vcount_s), .hsync(hsync_s), .vsync(vsync_s),
      .hblnk(hblnk_s), .vblnk(vblnk_s), .rgb(rgb_s),
      .line_start(line_start_s), .frame_start(frame_start_s)
   );

`ifdef VGA_TIMING_TEST_PATTERN_EN
   localparam logic [11:0] EXP_RGB50 = 12'hFFF;
`else
   localparam logic [11:0] EXP_RGB50 = 12'h000;
`endif

   function automatic logic [11:0] exp_rgb(input int h, input int v);
`ifdef VGA_TIMING_TEST_PATTERN_EN
      if (h >= 800 || v >= 600) return 12'h000;
      case (h / 100)
         0: return 12'hFFF;
         1: return 12'hFF0;
         2: return 12'h0FF;
         3: return 12'h0F0;
         4: return 12'hF0F;
         5: return 12'hF00;
         6: return 12'h00F;
         default: return 12'h000;
      endcase
`else
      if (h < 0 || v < 0) return 12'hFFF;
      return 12'h000;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int h, v, hs_cnt, hb_cnt, al_err, rgb_err, fs_cnt, fs_at, vs_cnt, vb_cnt;
      logic [11:0] rgb50, rgb750, rgb900;

      rst = 1'b0; en = 1'b0; rst_s = 1'b0; en_s = 1'b0;
      wait_neg(3);
      chk("rst_hcount", hcount, 0);
      chk("rst_vcount", vcount, 0);
      chk("rst_hsync", hsync, 0);
      chk("rst_vsync", vsync, 0);
      chk("rst_hblnk", hblnk, 0);
      chk("rst_vblnk", vblnk, 0);
      chk("rst_rgb", rgb, 0);
      chk("rst_line", line_start, 1);
      chk("rst_frame", frame_start, 1);

      rst = 1'b1; en = 1'b1;
      wait_neg(1);
      chk("first_h", hcount, 1);
      chk("first_line", line_start, 0);
      chk("first_frame", frame_start, 0);
      wait_neg(199);
      chk("pre_rst_h", hcount, 200);

      // asynchronous reset mid-line
      #1 rst = 1'b0;
      #1;
      chk("async_rst_h", hcount, 0);
      chk("async_rst_line", line_start, 1);
      wait_neg(2);
      chk("held_rst_h", hcount, 0);
      chk("held_rst_hsync", hsync, 0);
      rst = 1'b1;
      wait_neg(1);
      chk("post_rst_h", hcount, 1);
      chk("post_rst_v", vcount, 0);

      // one full line: window widths and per-cycle alignment with hcount
      hs_cnt = 0; hb_cnt = 0; al_err = 0;
      for (int i = 0; i < 1056; i++) begin
         h = int'(hcount);
         if (h != (i + 1) % 1056) al_err++;
         if (hsync === 1'b1) hs_cnt++;
         if (hblnk === 1'b1) hb_cnt++;
         if (hsync !== (h >= 840 && h <= 967)) al_err++;
         if (hblnk !== (h >= 800)) al_err++;
         if (vsync !== 1'b0 || vblnk !== 1'b0) al_err++;
         if (rgb !== exp_rgb(h, int'(vcount))) al_err++;
         wait_neg(1);
      end
      chk("hsync_width", hs_cnt, 128);
      chk("hblnk_width", hb_cnt, 256);
      chk("line_align", al_err, 0);
      chk("line_end_h", hcount, 1);
      chk("line_end_v", vcount, 1);

      // line boundary at vcount 5
      wait_neg(5278);
      chk("h1055", hcount, 1055);
      chk("v5", vcount, 5);
      chk("line_pre", line_start, 0);
      wait_neg(1);
      chk("wrap_h", hcount, 0);
      chk("wrap_v", vcount, 6);
      chk("wrap_line", line_start, 1);
      chk("wrap_frame", frame_start, 0);
      wait_neg(1);
      chk("line_one_cycle", line_start, 0);

      // line 10 colour content
      wait_neg(4223);
      chk("l10_h", hcount, 0);
      chk("l10_v", vcount, 10);
      rgb_err = 0; rgb50 = 12'hBAD; rgb750 = 12'hBAD; rgb900 = 12'hBAD;
      for (int i = 0; i < 1056; i++) begin
         h = int'(hcount);
         if (rgb !== exp_rgb(h, int'(vcount))) rgb_err++;
         if (h == 50)  rgb50  = rgb;
         if (h == 750) rgb750 = rgb;
         if (h == 900) rgb900 = rgb;
         wait_neg(1);
      end
      chk("rgb_line10", rgb_err, 0);
      chk("rgb_h50", rgb50, EXP_RGB50);
      chk("rgb_h750", rgb750, 12'h000);
      chk("rgb_h900", rgb900, 12'h000);

      // enable hold at hcount 500
      wait_neg(500);
      chk("pause_h", hcount, 500);
      en = 1'b0;
      wait_neg(10);
      chk("hold_h", hcount, 500);
      chk("hold_v", vcount, 11);
      chk("hold_hsync", hsync, 0);
      chk("hold_hblnk", hblnk, 0);
      chk("hold_line", line_start, 0);
      en = 1'b1;
      wait_neg(1);
      chk("resume_h", hcount, 501);

      // enable hold inside the sync pulse
      wait_neg(399);
      chk("pause2_h", hcount, 900);
      en = 1'b0;
      wait_neg(10);
      chk("hold2_h", hcount, 900);
      chk("hold2_hsync", hsync, 1);
      chk("hold2_hblnk", hblnk, 1);
      en = 1'b1;
      wait_neg(1);
      chk("resume2_h", hcount, 901);

      // small raster: reset polarity, frame wrap, strobe hold, frame period
      chk("s_rst_hsync", hsync_s, 1);
      chk("s_rst_vsync", vsync_s, 1);
      chk("s_rst_rgb", rgb_s, 0);
      rst_s = 1'b1; en_s = 1'b1;
      wait_neg(1);
      chk("s_first_h", hcount_s, 1);
      wait_neg(178);
      chk("s_last_h", hcount_s, 14);
      chk("s_last_v", vcount_s, 11);
      chk("s_last_vblnk", vblnk_s, 1);
      chk("s_last_frame", frame_start_s, 0);
      wait_neg(1);
      chk("s_wrap_h", hcount_s, 0);
      chk("s_wrap_v", vcount_s, 0);
      chk("s_wrap_frame", frame_start_s, 1);
      chk("s_wrap_line", line_start_s, 1);
      chk("s_wrap_vblnk", vblnk_s, 0);
      en_s = 1'b0;
      wait_neg(5);
      chk("s_hold_h", hcount_s, 0);
      chk("s_hold_frame", frame_start_s, 1);
      chk("s_hold_line", line_start_s, 1);
      en_s = 1'b1;
      wait_neg(1);
      chk("s_resume_h", hcount_s, 1);
      chk("s_resume_frame", frame_start_s, 0);

      fs_cnt = 0; fs_at = -1; vs_cnt = 0; vb_cnt = 0; al_err = 0;
      for (int i = 0; i < 180; i++) begin
         h = int'(hcount_s);
         v = int'(vcount_s);
         if (frame_start_s === 1'b1) begin fs_cnt++; fs_at = i; end
         if (vsync_s === 1'b0) vs_cnt++;
         if (vblnk_s === 1'b1) vb_cnt++;
         if (vsync_s !== !(v >= 7 && v <= 8)) al_err++;
         if (vblnk_s !== (v >= 6)) al_err++;
         if (hsync_s !== !(h >= 10 && h <= 12)) al_err++;
         if (hblnk_s !== (h >= 8)) al_err++;
         if (line_start_s !== (h == 0)) al_err++;
         wait_neg(1);
      end
      chk("s_frame_count", fs_cnt, 1);
      chk("s_frame_period", fs_at, 179);
      chk("s_vsync_clks", vs_cnt, 30);
      chk("s_vblnk_clks", vb_cnt, 90);
      chk("s_align", al_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the vga_if stream; produces hcount, vcount, hsync, vsync, hblnk and vblnk from a pixel clock.
- First stage of the video pipeline; every downstream overlay stage (background, targets, cursor) consumes its vga_if.out.
- Default timing is 800x600 @ 60 Hz (40 MHz pixel clock), positive sync polarity.
- Also emits per-line and per-frame strobes for game-logic pacing.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels); H_TOTAL = 1056
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines); V_TOTAL = 628
- SYNC_POL, 1'b1, active level of hsync and vsync

Ports:
- clk  in  1  pixel clock, 40 MHz
- rst  in  1  asynchronous, active-low reset
- en  in  1  count enable; when low, counters and all outputs hold
- out  vga_if.out  -  hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]
- line_start  out  1  one-cycle strobe while hcount==0
- frame_start  out  1  one-cycle strobe while hcount==0 and vcount==0

Behaviour:
- Reset (rst low, asynchronous):
  - hcount=0, vcount=0, hblnk=0, vblnk=0, rgb=0, line_start=1, frame_start=1.
  - hsync and vsync are driven to ~SYNC_POL (inactive).
  - All outputs are consistent with position (0,0).
- Counting:
  - hcount increments by 1 each clk while en is high.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At V_TOTAL-1 with hcount==H_TOTAL-1, both counters wrap to 0.
- Registered outputs: hsync, vsync, hblnk, vblnk and the strobes are registered. They are decoded from the next-count values, so every output is aligned with the hcount/vcount on the same cycle. Zero skew between counts and flags.
- Horizontal decode (default widths):
  - hblnk is high for hcount 800..1055.
  - hsync is at SYNC_POL for hcount 840..967.
- Vertical decode (default widths):
  - vblnk is high for vcount 600..627.
  - vsync is at SYNC_POL for vcount 601..604.
  - The vertical flags are evaluated on vcount alone; they change on the same cycle vcount changes (hcount==0).
- rgb: 12'h000 at all times in the base build.
- Enable:
  - en low freezes all registers, with no wrap and no strobe re-issue.
  - Strobes stay at their frozen value while held.
  - en high resumes counting from the held position.
- Reset mid-frame: immediate return to the reset state; counting restarts at (0,0) on the first enabled edge after release.
- Elaboration checks: each parameter must be ≥1, and H_TOTAL and V_TOTAL must be <2048. Otherwise, fail elaboration with $error.

Optional Feature:
- Macro: VGA_TIMING_TEST_PATTERN_EN.
- Defined: rgb shows 8 vertical colour bars, each H_ACTIVE/8 = 100 px wide, in this order: white F_F_F, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - Bar index = hcount/100, registered and aligned like the flags.
  - rgb is 0 whenever hblnk or vblnk is high.
- Not defined: rgb is constant 0 and no bar logic is synthesised.

Decomposition:
- Shared package vga_pkg holds:
  - the default timing constants (H_*/V_* and totals);
  - the 11-bit count width;
  - the 12-bit rgb width;
  - the bar colour constants.
- Natural sub-module: vga_axis_counter, one instance per axis.
  - Inputs: a parameterised total, a step enable and a wrap output.
  - It decodes the blank and sync windows for that axis.
  - The horizontal instance's wrap drives the vertical instance's step.

Test Plan:
- Assert rst low mid-count, then release → outputs read 0/0, sync inactive, blanks 0 while low; hcount reaches 1 on the first enabled edge after release.
- Free-run one line → hsync active exactly for hcount 840..967 (128 clks) and hblnk for 800..1055 (256 clks); both are aligned with hcount on the same cycle.
- Reach hcount=1055, vcount=5 → next clk gives hcount=0, vcount=6 with line_start=1 for exactly one cycle.
- Reach hcount=1055, vcount=627 → next clk gives 0/0 with frame_start=1; vsync was active for vcount 601..604; frame period is 663168 clks.
- Drop en for 10 clks at hcount=500 → hcount stays 500 and all flags are unchanged; resuming gives 501.
- With VGA_TIMING_TEST_PATTERN_EN defined, on line 10 → rgb is FFF at hcount 0..99, 000 at 700..799, and 0 in blanking. Without the macro, rgb stays 0 throughout.
